pg_out_monitor: RTL and testbench

- Response-capture stage directly downstream of the pattern-generator core in the tt_um_htfab_pg_1x1 top level.
- Samples the core's 8-bit output bus for a programmable window of cycles. Accumulates a 16-bit MISR signature, a transition count and stuck-at masks.
- Results are read back a byte at a time through a registered readout mux, so silicon results can be compared against the cocotb model.

---
 rtl/pg_out_monitor_if.sv | 29 ++
 rtl/pg_out_monitor.sv | 133 +++++++++++++
 tb/tb_pg_out_monitor.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pg_out_monitor_if.sv
// pg_out_monitor_if: control, observation and readout signals of the
// pattern-generator output monitor.
//   ena        design enable (low freezes the monitor)
//   start      single-cycle capture request
//   win_len    capture window length, 0 encodes 2^WIN_W
//   sample_in  core output bus under observation
//   rd_sel     readout byte select
//   rd_data    registered readout byte
//   busy/done  capture status
interface pg_out_monitor_if #(parameter int WIN_W = 8);
   logic             ena;
   logic             start;
   logic [WIN_W-1:0] win_len;
   logic [7:0]       sample_in;
   logic [2:0]       rd_sel;
   logic [7:0]       rd_data;
   logic             busy;
   logic             done;

   modport master (
      output ena, start, win_len, sample_in, rd_sel,
      input  rd_data, busy, done
   );

   modport slave (
      input  ena, start, win_len, sample_in, rd_sel,
      output rd_data, busy, done
   );
endinterface

// File: rtl/pg_out_monitor.sv
// pg_out_monitor: response-capture stage behind the pattern-generator core.
// Samples the 8-bit core output for a programmable window and accumulates a
// 16-bit MISR signature, a saturating transition count and stuck-at masks.
// Results are read back a byte at a time through a registered mux.
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    pg_out_monitor_if.slave (ena, start, win_len, sample_in, rd_sel,
//          rd_data, busy, done)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start, accumulators at reset/seed values
// ST_ARM     | one cycle: take the reference sample for transition count
// ST_CAPTURE | accumulate one sample per enabled cycle
// ST_DONE    | results held until the next start
module pg_out_monitor #(
   parameter int WIN_W = 8
) (
   input logic             clk,
   input logic             rst_n,
   pg_out_monitor_if.slave bus
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARM     = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   localparam logic [WIN_W:0] WIN_MAX = {1'b1, {WIN_W{1'b0}}};
   localparam logic [WIN_W:0] REM_ONE = {{WIN_W{1'b0}}, 1'b1};

   logic [1:0]     state_q, state_d;
   logic [15:0]    misr_q, misr_d;
   logic [15:0]    trans_q, trans_d;
   logic [7:0]     or_acc_q, or_acc_d;
   logic [7:0]     and_acc_q, and_acc_d;
   logic [WIN_W:0] remaining_q, remaining_d;
   logic [7:0]     prev_q, prev_d;
   logic [7:0]     rd_data_q, rd_data_d;

   logic           busy;
   logic           done;
   logic           fb;

   assign busy = (state_q == ST_ARM) || (state_q == ST_CAPTURE);
   assign done = (state_q == ST_DONE);

   // Taps x^16 + x^15 + x^13 + x^4 + 1 (bits 15, 14, 12, 3 of the register)
   assign fb = misr_q[15] ^ misr_q[14] ^ misr_q[12] ^ misr_q[3];

   always_comb begin
      state_d     = state_q;
      misr_d      = misr_q;
      trans_d     = trans_q;
      or_acc_d    = or_acc_q;
      and_acc_d   = and_acc_q;
      remaining_d = remaining_q;
      prev_d      = prev_q;
      rd_data_d   = rd_data_q;

      if (bus.ena) begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  state_d     = ST_ARM;
                  remaining_d = (bus.win_len == '0) ? WIN_MAX : {1'b0, bus.win_len};
                  misr_d      = 16'hFFFF;
                  trans_d     = 16'h0000;
                  or_acc_d    = 8'h00;
                  and_acc_d   = 8'hFF;
               end
            end
            ST_ARM: begin
               prev_d  = bus.sample_in;
               state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
               misr_d = {misr_q[14:0], fb} ^ {8'h00, bus.sample_in};
               if ((bus.sample_in != prev_q) && (trans_q != 16'hFFFF)) begin
                  trans_d = trans_q + 16'd1;
               end
               or_acc_d    = or_acc_q | bus.sample_in;
               and_acc_d   = and_acc_q & bus.sample_in;
               prev_d      = bus.sample_in;
               remaining_d = remaining_q - REM_ONE;
               if (remaining_q == REM_ONE) begin
                  state_d = ST_DONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         // Readout samples the current registers, so it never disturbs capture
         case (bus.rd_sel)
            3'd0:    rd_data_d = misr_q[7:0];
            3'd1:    rd_data_d = misr_q[15:8];
            3'd2:    rd_data_d = trans_q[7:0];
            3'd3:    rd_data_d = trans_q[15:8];
            3'd4:    rd_data_d = or_acc_q;
            3'd5:    rd_data_d = and_acc_q;
            3'd6:    rd_data_d = {done, busy, 6'b0};
            default: rd_data_d = 8'(remaining_q);
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         misr_q      <= 16'hFFFF;
         trans_q     <= 16'h0000;
         or_acc_q    <= 8'h00;
         and_acc_q   <= 8'hFF;
         remaining_q <= '0;
         prev_q      <= 8'h00;
         rd_data_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         misr_q      <= misr_d;
         trans_q     <= trans_d;
         or_acc_q    <= or_acc_d;
         and_acc_q   <= and_acc_d;
         remaining_q <= remaining_d;
         prev_q      <= prev_d;
         rd_data_q   <= rd_data_d;
      end
   end

   assign bus.rd_data = rd_data_q;
   assign bus.busy    = busy;
   assign bus.done    = done;

endmodule

// File: tb/tb_pg_out_monitor.sv
// tb_pg_out_monitor: directed and randomized capture runs of pg_out_monitor,
// checked against a reference computed from the captured sample list.
module tb_pg_out_monitor;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   pg_out_monitor_if #(.WIN_W(8)) bus ();

   pg_out_monitor #(.WIN_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // smp[0] is the ARM-cycle sample, smp[1..smp_n] are the captured samples
   logic [7:0]  smp [0:300];
   int          smp_n;
   logic [15:0] exp_misr;
   logic [15:0] exp_trans;
   logic [7:0]  exp_or;
   logic [7:0]  exp_and;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Signature as a polynomial division: shift left, feed back the parity of
   // the tapped bits, then fold in the sample byte.
   task automatic compute_model();
      int unsigned tcount;
      int unsigned m;
      m        = 32'hFFFF;
      tcount   = 0;
      exp_or   = 8'h00;
      exp_and  = 8'hFF;
      for (int i = 1; i <= smp_n; i++) begin
         m = (((m << 1) & 32'hFFFF) | 32'(^(m & 32'hD008))) ^ 32'(smp[i]);
         if (smp[i] != smp[i-1]) tcount++;
         exp_or  = exp_or | smp[i];
         exp_and = exp_and & smp[i];
      end
      exp_misr  = 16'(m);
      exp_trans = (tcount > 65535) ? 16'hFFFF : 16'(tcount);
   endtask

   task automatic read_byte(input logic [2:0] sel, output logic [7:0] val);
      bus.rd_sel = sel;
      step();
      val = bus.rd_data;
   endtask

   task automatic verify_results(input string tag);
      logic [7:0] v;
      compute_model();
      check({tag, "_done"}, 32'(bus.done), 32'd1);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      read_byte(3'd0, v); check({tag, "_misr_lo"},  32'(v), 32'(exp_misr[7:0]));
      read_byte(3'd1, v); check({tag, "_misr_hi"},  32'(v), 32'(exp_misr[15:8]));
      read_byte(3'd2, v); check({tag, "_trans_lo"}, 32'(v), 32'(exp_trans[7:0]));
      read_byte(3'd3, v); check({tag, "_trans_hi"}, 32'(v), 32'(exp_trans[15:8]));
      read_byte(3'd4, v); check({tag, "_or"},       32'(v), 32'(exp_or));
      read_byte(3'd5, v); check({tag, "_and"},      32'(v), 32'(exp_and));
      read_byte(3'd6, v); check({tag, "_status"},   32'(v), 32'h80);
      read_byte(3'd7, v); check({tag, "_remain"},   32'(v), 32'h00);
   endtask

   // mode 0: constant val, 1: alternating 00/FF from 00, 2: random
   task automatic run_capture(input int wl, input int mode, input logic [7:0] val,
                              input int gap_at, input int gap_len, input int restart_at,
                              output int busy_cycles);
      int         n;
      int         idx;
      int         gap_done;
      int         guard;
      logic [7:0] frozen;
      n = (wl == 0) ? 256 : wl;
      for (int i = 0; i <= n; i++) begin
         case (mode)
            0:       smp[i] = val;
            1:       smp[i] = (i % 2 == 1) ? 8'hFF : 8'h00;
            default: smp[i] = 8'($urandom);
         endcase
      end
      smp_n       = n;
      bus.ena     = 1'b1;
      bus.win_len = 8'(wl);
      bus.start   = 1'b1;
      step();
      bus.start   = 1'b0;
      busy_cycles = 0;
      idx         = 0;
      gap_done    = 0;
      guard       = 0;
      frozen      = 8'h00;
      while (bus.busy === 1'b1 && guard < 2000) begin
         guard++;
         busy_cycles++;
         if (restart_at >= 0 && idx == restart_at) begin
            bus.start   = 1'b1;
            bus.win_len = 8'd3;
         end else begin
            bus.start = 1'b0;
         end
         if (gap_len > 0 && idx == gap_at && gap_done < gap_len) begin
            if (gap_done == 0) frozen = bus.rd_data;
            bus.ena       = 1'b0;
            bus.sample_in = 8'($urandom);
            bus.rd_sel    = 3'($urandom);
            gap_done++;
            step();
            check("rd_frozen", 32'(bus.rd_data), 32'(frozen));
         end else begin
            bus.ena       = 1'b1;
            bus.sample_in = (idx <= n) ? smp[idx] : 8'h00;
            bus.rd_sel    = 3'($urandom);
            idx++;
            step();
         end
      end
      bus.start  = 1'b0;
      bus.ena    = 1'b1;
      bus.rd_sel = 3'd0;
      check("busy_bounded", 32'(guard < 2000), 32'd1);
   endtask

   initial begin
      int         bc;
      int         wl;
      logic [7:0] v;
      errors        = 0;
      checks        = 0;
      rst_n         = 1'b0;
      bus.ena       = 1'b0;
      bus.start     = 1'b0;
      bus.win_len   = 8'd0;
      bus.sample_in = 8'h00;
      bus.rd_sel    = 3'd0;
      step();
      step();
      check("rst_busy",    32'(bus.busy),    32'd0);
      check("rst_done",    32'(bus.done),    32'd0);
      check("rst_rd_data", 32'(bus.rd_data), 32'd0);
      rst_n   = 1'b1;
      bus.ena = 1'b1;
      step();

      // idle readout of reset values
      read_byte(3'd0, v); check("idle_misr_lo", 32'(v), 32'hFF);
      read_byte(3'd1, v); check("idle_misr_hi", 32'(v), 32'hFF);
      read_byte(3'd4, v); check("idle_or",      32'(v), 32'h00);
      read_byte(3'd5, v); check("idle_and",     32'(v), 32'hFF);
      read_byte(3'd2, v); check("idle_trans",   32'(v), 32'h00);
      read_byte(3'd6, v); check("idle_status",  32'(v), 32'h00);

      // single sample of 0x00
      run_capture(1, 0, 8'h00, -1, 0, -1, bc);
      check("w1_zero_busy", 32'(bc), 32'd2);
      verify_results("w1_zero");
      read_byte(3'd0, v); check("w1_zero_misr_lo_const", 32'(v), 32'hFE);
      read_byte(3'd1, v); check("w1_zero_misr_hi_const", 32'(v), 32'hFF);

      // single sample of 0xA5
      run_capture(1, 0, 8'hA5, -1, 0, -1, bc);
      check("w1_a5_busy", 32'(bc), 32'd2);
      verify_results("w1_a5");
      read_byte(3'd0, v); check("w1_a5_misr_lo_const", 32'(v), 32'h5B);
      read_byte(3'd2, v); check("w1_a5_trans_const",   32'(v), 32'h00);
      read_byte(3'd4, v); check("w1_a5_or_const",      32'(v), 32'hA5);

      // alternating 00/FF, four captures
      run_capture(4, 1, 8'h00, -1, 0, -1, bc);
      check("alt_busy", 32'(bc), 32'd5);
      verify_results("alt");
      read_byte(3'd2, v); check("alt_trans_const", 32'(v), 32'h04);
      read_byte(3'd4, v); check("alt_or_const",    32'(v), 32'hFF);
      read_byte(3'd5, v); check("alt_and_const",   32'(v), 32'h00);

      // full 256-sample window with an ignored second start
      run_capture(0, 2, 8'h00, -1, 0, 100, bc);
      check("w256_busy", 32'(bc), 32'd257);
      verify_results("w256");

      // 10-cycle enable gap mid-window
      run_capture(20, 2, 8'h00, 7, 10, -1, bc);
      check("gap_busy", 32'(bc), 32'd31);
      verify_results("gap");

      // done holds while idle
      repeat (5) step();
      check("done_hold", 32'(bus.done), 32'd1);

      // random windows
      for (int k = 0; k < 6; k++) begin
         wl = int'($urandom_range(1, 40));
         run_capture(wl, 2, 8'h00, -1, 0, -1, bc);
         check("rand_busy", 32'(bc), 32'(wl + 1));
         verify_results("rand");
      end

      // reset in the middle of a capture
      bus.win_len = 8'd50;
      bus.start   = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (5) begin
         bus.sample_in = 8'($urandom);
         step();
      end
      check("mid_busy_before_rst", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy",    32'(bus.busy),    32'd0);
      check("mid_rst_done",    32'(bus.done),    32'd0);
      check("mid_rst_rd_data", 32'(bus.rd_data), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      read_byte(3'd0, v); check("post_rst_misr_lo", 32'(v), 32'hFF);
      read_byte(3'd1, v); check("post_rst_misr_hi", 32'(v), 32'hFF);
      read_byte(3'd7, v); check("post_rst_remain",  32'(v), 32'h00);
      run_capture(1, 0, 8'h00, -1, 0, -1, bc);
      check("post_rst_busy", 32'(bc), 32'd2);
      verify_results("post_rst");
      read_byte(3'd0, v); check("post_rst_w1_misr_lo", 32'(v), 32'hFE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
